// File: rtl/alu_operand_entry.sv
// Debounced single-button entry of two 4-bit ALU operands and a 3-bit opcode.
// Optional macro ALU_ENTRY_SYNC_EN adds 2-flop synchronizers on btn and clr.
module alu_operand_entry #(
    parameter int DB_CYCLES = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] sw,
    input  logic       btn,
    input  logic       clr,
    output logic [3:0] a,
    output logic [3:0] b,
    output logic [2:0] op,
    output logic [1:0] phase,
    output logic       valid,
    output logic       start
);

    // Handshake: no ready/valid flow control here. valid is a level that is high
    // for the whole S_SHOW visit; start marks only its first cycle.
    typedef enum logic [1:0] {
        S_A    = 2'd0,
        S_B    = 2'd1,
        S_OP   = 2'd2,
        S_SHOW = 2'd3
    } state_t;

    localparam logic [15:0] DB_LAST = 16'(DB_CYCLES - 1);

    logic        w_btn;
    logic        w_clr;
    logic [15:0] r_db_cnt;
    logic        r_db_level;
    logic        r_db_prev;
    logic        r_step;

    state_t      r_state, w_state_nxt;
    logic [3:0]  r_a, w_a_nxt;
    logic [3:0]  r_b, w_b_nxt;
    logic [2:0]  r_op, w_op_nxt;
    logic        r_start, w_start_nxt;

`ifdef ALU_ENTRY_SYNC_EN
    logic r_btn_s1, r_btn_s2, r_clr_s1, r_clr_s2;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_btn_s1 <= 1'b0;
            r_btn_s2 <= 1'b0;
            r_clr_s1 <= 1'b0;
            r_clr_s2 <= 1'b0;
        end else begin
            r_btn_s1 <= btn;
            r_btn_s2 <= r_btn_s1;
            r_clr_s1 <= clr;
            r_clr_s2 <= r_clr_s1;
        end
    end

    assign w_btn = r_btn_s2;
    assign w_clr = r_clr_s2;
`else
    assign w_btn = btn;
    assign w_clr = clr;
`endif

    // The counter tracks cycles of disagreement; the toggle fires on the edge it would hit DB_CYCLES.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_db_cnt   <= 16'd0;
            r_db_level <= 1'b0;
            r_db_prev  <= 1'b0;
            r_step     <= 1'b0;
        end else begin
            r_db_prev <= r_db_level;
            r_step    <= r_db_level & ~r_db_prev;
            if (w_btn == r_db_level) begin
                r_db_cnt <= 16'd0;
            end else if (r_db_cnt == DB_LAST) begin
                r_db_cnt   <= 16'd0;
                r_db_level <= ~r_db_level;
            end else begin
                r_db_cnt <= r_db_cnt + 16'd1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_A;
            r_a     <= 4'd0;
            r_b     <= 4'd0;
            r_op    <= 3'd0;
            r_start <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_a     <= w_a_nxt;
            r_b     <= w_b_nxt;
            r_op    <= w_op_nxt;
            r_start <= w_start_nxt;
        end
    end

    // clr wins over a coincident step; the step pulse is simply dropped.
    always_comb begin
        w_state_nxt = r_state;
        w_a_nxt     = r_a;
        w_b_nxt     = r_b;
        w_op_nxt    = r_op;
        w_start_nxt = 1'b0;
        if (w_clr) begin
            w_state_nxt = S_A;
            w_a_nxt     = 4'd0;
            w_b_nxt     = 4'd0;
            w_op_nxt    = 3'd0;
        end else if (r_step) begin
            case (r_state)
                S_A: begin
                    w_a_nxt     = sw;
                    w_state_nxt = S_B;
                end
                S_B: begin
                    w_b_nxt     = sw;
                    w_state_nxt = S_OP;
                end
                S_OP: begin
                    w_op_nxt    = sw[2:0];
                    w_state_nxt = S_SHOW;
                    w_start_nxt = 1'b1;
                end
                default: begin
                    w_state_nxt = S_A;
                end
            endcase
        end
    end

    assign a     = r_a;
    assign b     = r_b;
    assign op    = r_op;
    assign phase = r_state;
    assign valid = (r_state == S_SHOW);
    assign start = r_start;

endmodule

// File: tb/tb_alu_operand_entry.sv
// Directed bench for alu_operand_entry with DB_CYCLES=4; honours ALU_ENTRY_SYNC_EN.
module tb_alu_operand_entry;

`ifdef ALU_ENTRY_SYNC_EN
    localparam int LAT = 7;
`else
    localparam int LAT = 5;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] sw  = 4'd0;
    logic       btn = 1'b0;
    logic       clr = 1'b0;
    logic [3:0] a, b;
    logic [2:0] op;
    logic [1:0] phase;
    logic       valid, start;

    int n_checks = 0;
    int n_pass   = 0;

    alu_operand_entry #(.DB_CYCLES(4)) dut (
        .clk(clk), .rst(rst), .sw(sw), .btn(btn), .clr(clr),
        .a(a), .b(b), .op(op), .phase(phase), .valid(valid), .start(start)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0] sw;
        logic [3:0] a;
        logic [3:0] b;
        logic [2:0] op;
        logic [1:0] phase;
        logic       valid;
        int         starts;
    } vec_t;

    vec_t vecs[10];

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Hold btn 12 cycles then release 10; report press-to-phase-change latency and start pulses.
    task automatic press(input logic [3:0] v, output int lat, output int starts);
        logic [1:0] prev;
        @(negedge clk);
        prev   = phase;
        sw     = v;
        btn    = 1'b1;
        lat    = -1;
        starts = 0;
        for (int i = 1; i <= 12; i++) begin
            tick();
            if (lat < 0 && phase != prev) lat = i - 1;
            if (start) starts++;
        end
        @(negedge clk);
        btn = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (start) starts++;
        end
    endtask

    initial begin
        int lat, starts;
        logic [1:0] ph0;

        vecs[0] = '{4'd3, 4'd3, 4'd0,  3'd0, 2'd1, 1'b0, 0};
        vecs[1] = '{4'd5, 4'd3, 4'd5,  3'd0, 2'd2, 1'b0, 0};
        vecs[2] = '{4'd0, 4'd3, 4'd5,  3'd0, 2'd3, 1'b1, 1};
        vecs[3] = '{4'd9, 4'd3, 4'd5,  3'd0, 2'd0, 1'b0, 0};
        vecs[4] = '{4'd9, 4'd9, 4'd5,  3'd0, 2'd1, 1'b0, 0};
        vecs[5] = '{4'hC, 4'd9, 4'hC,  3'd0, 2'd2, 1'b0, 0};
        vecs[6] = '{4'hE, 4'd9, 4'hC,  3'd6, 2'd3, 1'b1, 1};
        vecs[7] = '{4'd1, 4'd9, 4'hC,  3'd6, 2'd0, 1'b0, 0};
        vecs[8] = '{4'd2, 4'd2, 4'hC,  3'd6, 2'd1, 1'b0, 0};
        vecs[9] = '{4'd5, 4'd2, 4'd5,  3'd6, 2'd2, 1'b0, 0};

        // Reset values while rst is held
        #12;
        check("rst_phase", phase, 0);
        check("rst_a", a, 0);
        check("rst_b", b, 0);
        check("rst_op", op, 0);
        check("rst_valid", valid, 0);
        check("rst_start", start, 0);
        @(negedge clk);
        rst = 1'b0;
        repeat (3) tick();

        for (int k = 0; k < 10; k++) begin
            press(vecs[k].sw, lat, starts);
            check($sformatf("v%0d_latency", k), lat, LAT);
            check($sformatf("v%0d_starts", k), starts, vecs[k].starts);
            check($sformatf("v%0d_a", k), a, vecs[k].a);
            check($sformatf("v%0d_b", k), b, vecs[k].b);
            check($sformatf("v%0d_op", k), op, vecs[k].op);
            check($sformatf("v%0d_phase", k), phase, vecs[k].phase);
            check($sformatf("v%0d_valid", k), valid, vecs[k].valid);
        end

        // Bounce 1,0,1,0,1 on single cycles: no step
        ph0 = phase;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            btn = (i % 2 == 0);
        end
        @(negedge clk);
        btn = 1'b0;
        repeat (15) tick();
        check("bounce_no_step", phase, ph0);
        press(4'd1, lat, starts);
        check("bounce_then_hold_phase", phase, 3);
        check("bounce_then_hold_op", op, 1);
        check("bounce_then_hold_start", starts, 1);
        press(4'd0, lat, starts);
        check("wrap2_phase", phase, 0);
        press(4'd4, lat, starts);
        check("to_sb_phase", phase, 1);
        check("to_sb_a", a, 4);

        // clr sampled on the same edge the S_B step would act
        @(negedge clk);
        sw  = 4'd7;
        btn = 1'b1;
        repeat (5) @(posedge clk);
        @(negedge clk);
        clr = 1'b1;
        @(negedge clk);
        clr = 1'b0;
        repeat (4) tick();
        check("clr_phase", phase, 0);
        check("clr_a", a, 0);
        check("clr_b", b, 0);
        check("clr_op", op, 0);
        repeat (6) tick();
        @(negedge clk);
        btn = 1'b0;
        repeat (10) tick();
        check("clr_step_discarded", phase, 0);

        // Reset mid-S_OP with a partial press in flight
        press(4'd3, lat, starts);
        press(4'd5, lat, starts);
        check("pre_rst_phase", phase, 2);
        @(negedge clk);
        btn = 1'b1;
        repeat (2) @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        check("async_rst_phase", phase, 0);
        check("async_rst_a", a, 0);
        check("async_rst_b", b, 0);
        check("async_rst_op", op, 0);
        check("async_rst_valid", valid, 0);
        btn = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        repeat (20) tick();
        check("post_rst_no_step", phase, 0);

        // btn already high at reset release is a fresh press
        @(negedge clk);
        rst = 1'b1;
        sw  = 4'd6;
        btn = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        repeat (30) tick();
        check("held_at_release_phase", phase, 1);
        check("held_at_release_a", a, 6);
        @(negedge clk);
        btn = 1'b0;
        repeat (10) tick();
        check("held_release_no_step", phase, 1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/alu_operand_entry.md
ALU_OPERAND_ENTRY -- requirements
Module: alu_operand_entry

Interface
REQ-001 SHALL have parameter DB_CYCLES, default 16, meaning the number of consecutive cycles the button must hold a new level before that level is accepted (legal range 2..65535).
REQ-002 SHALL have port clk  input  1  single system clock, rising-edge.
REQ-003 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-004 SHALL have port sw  input  4  switch value latched as an operand or opcode.
REQ-005 SHALL have port btn  input  1  raw step push-button, active-high, may bounce.
REQ-006 SHALL have port clr  input  1  synchronous clear, active-high.
REQ-007 SHALL have port a  output  4  latched ALU operand A.
REQ-008 SHALL have port b  output  4  latched ALU operand B.
REQ-009 SHALL have port op  output  3  latched ALU opcode.
REQ-010 SHALL have port phase  output  2  current state encoding: 0=S_A, 1=S_B, 2=S_OP, 3=S_SHOW.
REQ-011 SHALL have port valid  output  1  high while a, b and op form a complete operand set.
REQ-012 SHALL have port start  output  1  one-cycle pulse marking a new operand set.

Function
REQ-013 Debounce SHALL hold a counter of consecutive cycles with btn != db_level; the counter SHALL clear whenever btn == db_level.
REQ-014 db_level SHALL toggle on the edge where the counter would reach DB_CYCLES; the counter SHALL clear on that same edge.
REQ-015 step SHALL be a one-cycle internal pulse on db_level rising; a db_level fall SHALL NOT produce any action.
REQ-016 A held button SHALL yield exactly one step; bounce shorter than DB_CYCLES cycles SHALL yield none.
REQ-017 FSM on step: S_A latches a<=sw and enters S_B; S_B latches b<=sw and enters S_OP; S_OP latches op<=sw[2:0] and enters S_SHOW; S_SHOW enters S_A with a, b and op held.
REQ-018 Without step, the state and all latched registers SHALL hold.
REQ-019 The phase change SHALL become visible DB_CYCLES+1 cycles after btn is first sampled high and then held steady.
REQ-020 valid SHALL be 1 exactly when the state is S_SHOW.
REQ-021 start SHALL be 1 only in the first cycle of each S_SHOW entry.
REQ-022 clr SHALL force the state to S_A, clear a, b and op to 0, and clear start, all on the next edge.
REQ-023 clr SHALL take priority over a simultaneous step, which SHALL be discarded.
REQ-024 clr SHALL NOT affect the debounce counter or db_level.
REQ-025 All outputs SHALL be registered; there SHALL be no combinational path from any input to any output.

Reset
REQ-026 rst SHALL asynchronously set: state S_A, phase 0, a=0, b=0, op=0, valid=0, start=0, db_level=0, debounce counter 0, synchronizer flops 0.
REQ-027 rst asserted mid-entry (any state, counter nonzero) SHALL discard partial operands; after release the block SHALL require a fresh debounced press.
REQ-028 If btn is already high at rst release, it SHALL be debounced as a new press and produce one step.

Configuration
REQ-029 Macro ALU_ENTRY_SYNC_EN defined: btn and clr SHALL each pass through a 2-flop synchronizer before use, adding 2 cycles to every latency in REQ-019 and REQ-022.
REQ-030 Macro ALU_ENTRY_SYNC_EN undefined: btn and clr SHALL be used directly, and latencies SHALL be exactly as stated.

Verification (DB_CYCLES=4, macro undefined)
REQ-031 Reset: rst pulse mid-S_OP -> immediately phase=0, a=b=op=0, valid=0; with btn low after release, no step occurs.
REQ-032 Full entry: press/release with sw=3, then sw=5, then sw=0 -> a=3, b=5, op=0, phase=3, valid=1, start high exactly 1 cycle; phase changes 5 cycles after each press.
REQ-033 Bounce: btn toggles 1,0,1,0,1 on single cycles, then held low -> no phase change; then held high 10 cycles -> exactly one step.
REQ-034 Wrap: fourth press in S_SHOW -> phase=0, valid=0, a=3, b=5 and op=0 unchanged; next press with sw=9 -> a=9.
REQ-035 clr/step collision: clr asserted the same cycle step fires in S_B -> phase=0, b not latched, a=0.
REQ-036 Macro defined: repeat REQ-032 -> identical values; each phase change occurs 7 cycles after the press.
